// File: rtl/get_lookup_fsm.sv
// GET sub-FSM for the cache controller: latches a key, resolves the entry match vector,
// issues one value-store read with a timeout and reports hit, miss or error.
module get_lookup_fsm #(
    parameter int unsigned NUM_ENTRIES   = 16,
    parameter int unsigned KEY_W         = 32,
    parameter int unsigned VAL_W         = 64,
    parameter int unsigned TIMEOUT       = 8,
    parameter bit          MULTI_HIT_ERR = 1'b1,
    localparam int unsigned IDX_W        = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   enter,
    input  logic [KEY_W-1:0]       key_i,
    output logic [KEY_W-1:0]       key_o,
    input  logic [NUM_ENTRIES-1:0] hit_vec_i,
    output logic                   rd_en_o,
    output logic [IDX_W-1:0]       rd_idx_o,
    input  logic                   rd_valid_i,
    input  logic [VAL_W-1:0]       rd_data_i,
    output logic [VAL_W-1:0]       value_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   hit_o,
    output logic                   miss_o,
    output logic                   err_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MATCH,
        ST_READ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              drain_q, drain_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              err_q, err_d;
    logic              rd_en_c;

    logic [IDX_W-1:0]  low_idx;
    logic              multi_hit;
    logic              accept;

    // Lowest set index of the match vector; more than one bit set flags a multi-hit.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec_i[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign multi_hit = |(hit_vec_i & (hit_vec_i - NUM_ENTRIES'(1)));

    // A response belongs to the current read only when no stale read is pending.
    assign accept = (state_q == ST_WAIT) && rd_valid_i && !drain_q;

    // Next-state and datapath updates; enter overrides en.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        drain_d = drain_q;
        value_d = value_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        err_d   = err_q;
        rd_en_c = 1'b0;

        // Stale response from an aborted or timed-out read is swallowed in any state.
        if (drain_q && rd_valid_i) begin
            drain_d = 1'b0;
        end

        if (enter) begin
            state_d = ST_MATCH;
            key_d   = key_i;
            value_d = '0;
            hit_d   = 1'b0;
            miss_d  = 1'b0;
            err_d   = 1'b0;
            timer_d = '0;
            if ((state_q == ST_WAIT) && !accept) begin
                drain_d = 1'b1;
            end
        end else if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_MATCH: begin
                    if (hit_vec_i == '0) begin
                        miss_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (multi_hit && MULTI_HIT_ERR) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = low_idx;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    rd_en_c = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (accept) begin
                        value_d = rd_data_i;
                        hit_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (timer_q == TMR_LAST) begin
                        err_d   = 1'b1;
                        drain_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            drain_q <= 1'b0;
            value_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            drain_q <= drain_d;
            value_q <= value_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    assign key_o    = key_q;
    assign rd_en_o  = rd_en_c;
    assign rd_idx_o = idx_q;
    assign value_o  = value_q;
    assign hit_o    = hit_q;
    assign miss_o   = miss_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q == ST_MATCH) || (state_q == ST_READ) || (state_q == ST_WAIT);
    assign done_o   = (state_q == ST_DONE);

endmodule

// File: tb/tb_get_lookup_fsm.sv
// Directed bench for get_lookup_fsm: hit, miss, multi-hit (both policies), timeout/drain,
// abort, en gating and asynchronous reset.
module tb_get_lookup_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        enter = 1'b0;
    logic [31:0] key_i = '0;
    logic [15:0] hit_vec = '0;
    logic        rd_valid = 1'b0;
    logic [63:0] rd_data = '0;

    logic [31:0] key_o, key_o2;
    logic        rd_en, rd_en2;
    logic [3:0]  rd_idx, rd_idx2;
    logic [63:0] value, value2;
    logic        busy, busy2, done, done2, hit, hit2, miss, miss2, err, err2;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int start_pulses;

    always #5 clk = ~clk;

    always @(negedge clk) if (rd_en) rd_pulses++;

    get_lookup_fsm #(.NUM_ENTRIES(16), .KEY_W(32), .VAL_W(64), .TIMEOUT(8), .MULTI_HIT_ERR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .key_i(key_i), .key_o(key_o),
        .hit_vec_i(hit_vec), .rd_en_o(rd_en), .rd_idx_o(rd_idx), .rd_valid_i(rd_valid),
        .rd_data_i(rd_data), .value_o(value), .busy_o(busy), .done_o(done),
        .hit_o(hit), .miss_o(miss), .err_o(err)
    );

    get_lookup_fsm #(.NUM_ENTRIES(16), .KEY_W(32), .VAL_W(64), .TIMEOUT(8), .MULTI_HIT_ERR(1'b0)) dut_low (
        .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .key_i(key_i), .key_o(key_o2),
        .hit_vec_i(hit_vec), .rd_en_o(rd_en2), .rd_idx_o(rd_idx2), .rd_valid_i(rd_valid),
        .rd_data_i(rd_data), .value_o(value2), .busy_o(busy2), .done_o(done2),
        .hit_o(hit2), .miss_o(miss2), .err_o(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; enter = 1'b0; key_i = '0; hit_vec = '0; rd_valid = 1'b0; rd_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        if ({busy, done, hit, miss, err, rd_en} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {busy, done, hit, miss, err, rd_en});
        end
        checks++;
        if (key_o !== 32'h0 || rd_idx !== 4'h0 || value !== 64'h0) begin
            errors++; $display("FAIL reset_data got key %h idx %h val %h exp zeros", key_o, rd_idx, value);
        end
        checks++;
    endtask

    task automatic test_hit();
        do_reset();
        start_pulses = rd_pulses;
        enter = 1'b1; key_i = 32'hCAFE; hit_vec = 16'h0010; en = 1'b1;
        tick();
        enter = 1'b0; #1;
        if (key_o !== 32'hCAFE || busy !== 1'b1) begin
            errors++; $display("FAIL hit_match got key %h busy %b exp cafe 1", key_o, busy);
        end
        checks++;
        tick();
        if (rd_en !== 1'b1 || rd_idx !== 4'd4) begin
            errors++; $display("FAIL hit_read got rd_en %b idx %0d exp 1 4", rd_en, rd_idx);
        end
        checks++;
        tick();
        if (rd_en !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL hit_wait got rd_en %b busy %b exp 0 1", rd_en, busy);
        end
        checks++;
        tick();
        rd_valid = 1'b1; rd_data = 64'h0123_4567_89AB_CDEF;
        tick();
        rd_valid = 1'b0;
        if ({done, hit, miss, err} !== 4'b1100 || value !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL hit_done got dhme %b val %h exp 1100 0123456789abcdef", {done, hit, miss, err}, value);
        end
        checks++;
        tick();
        if (done !== 1'b0 || hit !== 1'b1 || rd_idx !== 4'd4) begin
            errors++; $display("FAIL hit_hold got done %b hit %b idx %0d exp 0 1 4", done, hit, rd_idx);
        end
        checks++;
        if (rd_pulses - start_pulses !== 1) begin
            errors++; $display("FAIL hit_pulses got %0d exp 1", rd_pulses - start_pulses);
        end
        checks++;
    endtask

    task automatic test_miss();
        do_reset();
        start_pulses = rd_pulses;
        enter = 1'b1; key_i = 32'h0BAD; hit_vec = 16'h0000; en = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        if ({done, hit, miss, err} !== 4'b1010) begin
            errors++; $display("FAIL miss_done got dhme %b exp 1010", {done, hit, miss, err});
        end
        checks++;
        tick();
        if (done !== 1'b0 || miss !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL miss_hold got done %b miss %b busy %b exp 0 1 0", done, miss, busy);
        end
        checks++;
        if (rd_pulses - start_pulses !== 0) begin
            errors++; $display("FAIL miss_pulses got %0d exp 0", rd_pulses - start_pulses);
        end
        checks++;
    endtask

    task automatic test_multi_hit();
        do_reset();
        start_pulses = rd_pulses;
        enter = 1'b1; key_i = 32'h0303; hit_vec = 16'h0300; en = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        if ({done, hit, miss, err} !== 4'b1001) begin
            errors++; $display("FAIL multi_err got dhme %b exp 1001", {done, hit, miss, err});
        end
        checks++;
        if (rd_en2 !== 1'b1 || rd_idx2 !== 4'd8) begin
            errors++; $display("FAIL multi_low_read got rd_en %b idx %0d exp 1 8", rd_en2, rd_idx2);
        end
        checks++;
        tick();
        rd_valid = 1'b1; rd_data = 64'hFEED_0000_0000_0008;
        tick();
        rd_valid = 1'b0;
        if ({done2, hit2, miss2, err2} !== 4'b1100 || value2 !== 64'hFEED_0000_0000_0008) begin
            errors++; $display("FAIL multi_low_hit got dhme %b val %h exp 1100 feed000000000008", {done2, hit2, miss2, err2}, value2);
        end
        checks++;
        if (hit !== 1'b0 || err !== 1'b1 || rd_pulses - start_pulses !== 0) begin
            errors++; $display("FAIL multi_err_hold got hit %b err %b pulses %0d exp 0 1 0", hit, err, rd_pulses - start_pulses);
        end
        checks++;
    endtask

    task automatic test_timeout();
        do_reset();
        enter = 1'b1; key_i = 32'h7777; hit_vec = 16'h0001; en = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        tick();
        repeat (7) tick();
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL timeout_early got busy %b err %b exp 1 0", busy, err);
        end
        checks++;
        tick();
        if ({done, hit, miss, err} !== 4'b1001) begin
            errors++; $display("FAIL timeout_err got dhme %b exp 1001", {done, hit, miss, err});
        end
        checks++;
        tick();
        rd_valid = 1'b1; rd_data = 64'hDEAD;
        tick();
        rd_valid = 1'b0;
        if (hit !== 1'b0 || err !== 1'b1 || value !== 64'h0) begin
            errors++; $display("FAIL timeout_late got hit %b err %b val %h exp 0 1 0", hit, err, value);
        end
        checks++;
        // Drain must have cleared: the next read's response is accepted.
        enter = 1'b1; key_i = 32'h8888; hit_vec = 16'h0002;
        tick();
        enter = 1'b0;
        tick();
        tick();
        rd_valid = 1'b1; rd_data = 64'hBEEF;
        tick();
        rd_valid = 1'b0;
        if ({done, hit, err} !== 3'b110 || value !== 64'hBEEF || rd_idx !== 4'd1) begin
            errors++; $display("FAIL timeout_next got dhe %b val %h idx %0d exp 110 beef 1", {done, hit, err}, value, rd_idx);
        end
        checks++;
    endtask

    task automatic test_abort();
        do_reset();
        enter = 1'b1; key_i = 32'h1111; hit_vec = 16'h0004; en = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        tick();
        enter = 1'b1; key_i = 32'h2222; hit_vec = 16'h0020;
        tick();
        enter = 1'b0;
        if (key_o !== 32'h2222 || busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL abort_restart got key %h busy %b err %b exp 2222 1 0", key_o, busy, err);
        end
        checks++;
        tick();
        tick();
        rd_valid = 1'b1; rd_data = 64'h0DD;
        tick();
        rd_valid = 1'b0;
        if (busy !== 1'b1 || hit !== 1'b0 || value !== 64'h0) begin
            errors++; $display("FAIL abort_stale got busy %b hit %b val %h exp 1 0 0", busy, hit, value);
        end
        checks++;
        tick();
        rd_valid = 1'b1; rd_data = 64'h0E0E;
        tick();
        rd_valid = 1'b0;
        if ({done, hit, err} !== 3'b110 || value !== 64'h0E0E || rd_idx !== 4'd5) begin
            errors++; $display("FAIL abort_new got dhe %b val %h idx %0d exp 110 e0e 5", {done, hit, err}, value, rd_idx);
        end
        checks++;
    endtask

    task automatic test_en_gating();
        do_reset();
        start_pulses = rd_pulses;
        enter = 1'b1; key_i = 32'h4444; hit_vec = 16'h0010; en = 1'b0;
        tick();
        enter = 1'b0;
        if (busy !== 1'b1 || key_o !== 32'h4444) begin
            errors++; $display("FAIL gate_enter got busy %b key %h exp 1 4444", busy, key_o);
        end
        checks++;
        tick();
        en = 1'b1;
        tick();
        en = 1'b0; #1;
        if (rd_en !== 1'b0 || rd_idx !== 4'd4) begin
            errors++; $display("FAIL gate_read_off got rd_en %b idx %0d exp 0 4", rd_en, rd_idx);
        end
        checks++;
        tick();
        en = 1'b1; #1;
        if (rd_en !== 1'b1) begin
            errors++; $display("FAIL gate_read_on got rd_en %b exp 1", rd_en);
        end
        checks++;
        tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        en = 1'b1; rd_valid = 1'b1; rd_data = 64'h5A5A;
        tick();
        en = 1'b0; rd_valid = 1'b0;
        tick();
        if (done !== 1'b1 || hit !== 1'b1 || value !== 64'h5A5A) begin
            errors++; $display("FAIL gate_done_hold got done %b hit %b val %h exp 1 1 5a5a", done, hit, value);
        end
        checks++;
        en = 1'b1;
        tick();
        if (done !== 1'b0 || rd_pulses - start_pulses !== 1) begin
            errors++; $display("FAIL gate_idle got done %b pulses %0d exp 0 1", done, rd_pulses - start_pulses);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        enter = 1'b1; key_i = 32'h9999; hit_vec = 16'h0008; en = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        if ({busy, done, hit, miss, err, rd_en} !== 6'b0 || key_o !== 32'h0 || rd_idx !== 4'h0) begin
            errors++; $display("FAIL async_reset got flags %b key %h idx %0d exp 0 0 0", {busy, done, hit, miss, err, rd_en}, key_o, rd_idx);
        end
        checks++;
        #1 rst_n = 1'b1;
        tick();
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL async_reset_idle got busy %b done %b exp 0 0", busy, done);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_multi_hit();
        test_timeout();
        test_abort();
        test_en_gating();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
